// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the IF/ID/EXE pipeline and its sequencer.
//   master : pipeline side; drives ID/EXE status, receives hold/bubble/flush controls
//   slave  : sequencer side (pipe_hazard_ctrl)
// Signals:
//   id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_muldiv : ID stage status
//   ex_rd_addr, ex_wb_en, ex_mem_rd, ex_br_taken                            : ID_EXE / EXE status
//   mem_wait                                                                : data memory not ready
//   stall_pc, stall_if_id, hold_id_exe, bubble_id_exe, flush_if_id,
//   hold_ex_mem                                                             : register controls
//   muldiv_busy, muldiv_done                                                : MUL/DIV occupancy status
//   stall_cycles                                                            : saturating stall counter
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_muldiv;
  logic [4:0]       ex_rd_addr;
  logic             ex_wb_en;
  logic             ex_mem_rd;
  logic             ex_br_taken;
  logic             mem_wait;
  logic             stall_pc;
  logic             stall_if_id;
  logic             hold_id_exe;
  logic             bubble_id_exe;
  logic             flush_if_id;
  logic             hold_ex_mem;
  logic             muldiv_busy;
  logic             muldiv_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_muldiv,
    output ex_rd_addr, ex_wb_en, ex_mem_rd, ex_br_taken, mem_wait,
    input  stall_pc, stall_if_id, hold_id_exe, bubble_id_exe, flush_if_id, hold_ex_mem,
    input  muldiv_busy, muldiv_done, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_muldiv,
    input  ex_rd_addr, ex_wb_en, ex_mem_rd, ex_br_taken, mem_wait,
    output stall_pc, stall_if_id, hold_id_exe, bubble_id_exe, flush_if_id, hold_ex_mem,
    output muldiv_busy, muldiv_done, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the IF/ID/EXE stages.
// Detects load-use hazards, tracks multi-cycle MUL/DIV occupancy of EXE, flushes on
// taken branches and freezes the whole pipe while data memory is not ready.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : synchronous active-low reset
//   bus : pipe_hazard_ctrl_if.slave (status in, hold/bubble/flush controls out,
//         MUL/DIV status and saturating stall-cycle counter out)
// Parameters:
//   MULDIV_LAT : EXE cycles occupied by a MUL/DIV (>= 2)
//   CNT_W      : width of the stall-cycle counter (must match the interface)
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(MULDIV_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;

  logic stall_pc, stall_if_id, hold_id_exe, bubble_id_exe;
  logic flush_if_id, hold_ex_mem, muldiv_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A load in EXE whose destination is read by the instruction in ID; x0 never conflicts.
  always_comb begin
    load_use = bus.ex_mem_rd & bus.ex_wb_en & (bus.ex_rd_addr != 5'd0) & bus.id_valid &
               ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr)));
  end

  // Next-state and control outputs, highest-priority condition first.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    hold_id_exe   = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    hold_ex_mem   = 1'b0;
    muldiv_done   = 1'b0;

    if (bus.mem_wait) begin
      // Whole pipe frozen; FSM and occupancy counter keep their values.
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      hold_id_exe = 1'b1;
      hold_ex_mem = 1'b1;
    end else if (state == IDLE && bus.ex_br_taken) begin
      // Wrong-path instructions in IF and ID are killed; any hazard they raised is moot.
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (state == BUSY) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      hold_id_exe = 1'b1;
      cnt_nxt     = cnt - CW'(1);
      if (cnt == CW'(1)) begin
        // Last EXE cycle: the result moves on and a bubble follows it, so the
        // waiting instruction in ID issues on the next cycle.
        muldiv_done   = 1'b1;
        hold_id_exe   = 1'b0;
        bubble_id_exe = 1'b1;
        state_nxt     = IDLE;
      end
    end else if (load_use) begin
      stall_pc      = 1'b1;
      stall_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (bus.id_valid && bus.id_muldiv) begin
      // MUL/DIV enters EXE this cycle and occupies it for MULDIV_LAT-1 more cycles.
      state_nxt = BUSY;
      cnt_nxt   = CW'(MULDIV_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_pc) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign bus.stall_pc      = stall_pc;
  assign bus.stall_if_id   = stall_if_id;
  assign bus.hold_id_exe   = hold_id_exe;
  assign bus.bubble_id_exe = bubble_id_exe;
  assign bus.flush_if_id   = flush_if_id;
  assign bus.hold_ex_mem   = hold_ex_mem;
  assign bus.muldiv_busy   = (state == BUSY);
  assign bus.muldiv_done   = muldiv_done;
  assign bus.stall_cycles  = stall_cnt;

endmodule
